// File: rtl/idct_pkg.sv
// Shared types and arithmetic helpers for the 4x4 inverse integer transform.
package idct_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL
    } bank_state_e;

    function automatic int unsigned row_width(input int unsigned in_w);
        return in_w + 2;
    endfunction

    function automatic int unsigned col_width(input int unsigned in_w);
        return in_w + 4;
    endfunction

    // Round half-up by 2^shift (arithmetic), then clamp to a signed out_w range.
    function automatic logic signed [31:0] round_sat(input logic signed [31:0] y,
                                                     input int unsigned        shift,
                                                     input int unsigned        out_w);
        logic signed [31:0] r;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        r = y;
        if (shift > 0) begin
            r = (y + (32'sd1 <<< (shift - 1))) >>> shift;
        end
        hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/idct4_1d.sv
// Combinational 4-point inverse integer butterfly; output grows by two bits.
module idct4_1d #(
    parameter int unsigned W = 13
) (
    input  logic [4*W-1:0]     x,
    output logic [4*(W+2)-1:0] y
);

    logic signed [W+1:0] x0, x1, x2, x3;
    logic signed [W+1:0] d0, d1, d2, d3;

    always_comb begin
        x0 = (W+2)'($signed(x[0*W +: W]));
        x1 = (W+2)'($signed(x[1*W +: W]));
        x2 = (W+2)'($signed(x[2*W +: W]));
        x3 = (W+2)'($signed(x[3*W +: W]));
        d0 = x0 + x2;
        d1 = x0 - x2;
        d2 = (x1 >>> 1) - x3;
        d3 = (x3 >>> 1) + x1;
        y  = {d0 - d3, d1 - d2, d1 + d2, d0 + d3};
    end

endmodule

// File: rtl/idct4x4_2d.sv
// Streaming 4x4 2D inverse transform: row butterfly, ping-pong transpose banks,
// column butterfly, round/saturate, and a single-entry handshaked output register.
module idct4x4_2d
    import idct_pkg::*;
#(
    parameter int unsigned IN_W  = 13,
    parameter int unsigned OUT_W = 9,
    parameter int unsigned SHIFT = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*IN_W-1:0]    in_row,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*OUT_W-1:0]   out_col,
    output logic                 out_last
);

    localparam int unsigned ROW_W = row_width(IN_W);
    localparam int unsigned COL_W = col_width(IN_W);

    logic [4*ROW_W-1:0] row_y;
    logic [4*ROW_W-1:0] col_x;
    logic [4*COL_W-1:0] col_y;
    logic [4*OUT_W-1:0] col_res;

    logic [4*ROW_W-1:0] bank_q [2][4];
    logic [4*ROW_W-1:0] bank_d [2][4];
    bank_state_e        bank_st_q [2];
    bank_state_e        bank_st_d [2];

    logic [1:0]         wr_cnt_q, wr_cnt_d;
    logic [1:0]         rd_cnt_q, rd_cnt_d;
    logic               wr_sel_q, wr_sel_d;
    logic               rd_sel_q, rd_sel_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic [4*OUT_W-1:0] out_col_q, out_col_d;
    logic               wr_fire, rd_fire;

    idct4_1d #(.W(IN_W)) u_row_pass (.x(in_row), .y(row_y));
    idct4_1d #(.W(ROW_W)) u_col_pass (.x(col_x), .y(col_y));

    // Column rd_cnt of the read bank: element i comes from stored row i.
    always_comb begin
        col_x = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            col_x[i*ROW_W +: ROW_W] = bank_q[rd_sel_q][i][rd_cnt_q*ROW_W +: ROW_W];
        end
    end

    always_comb begin
        col_res = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            col_res[i*OUT_W +: OUT_W] =
                OUT_W'(round_sat(32'(signed'(col_y[i*COL_W +: COL_W])), SHIFT, OUT_W));
        end
    end

    assign in_ready  = (bank_st_q[wr_sel_q] != BANK_FULL);
    assign out_valid = out_valid_q;
    assign out_col   = out_col_q;
    assign out_last  = out_last_q;

    // Writes and reads never target the same bank on one edge: a bank is written
    // only while not FULL and read only while FULL.
    always_comb begin
        wr_fire     = in_valid && in_ready;
        rd_fire     = (bank_st_q[rd_sel_q] == BANK_FULL) && (!out_valid_q || out_ready);
        bank_d      = bank_q;
        bank_st_d   = bank_st_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        wr_sel_d    = wr_sel_q;
        rd_sel_d    = rd_sel_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_col_d   = out_col_q;

        if (wr_fire) begin
            bank_d[wr_sel_q][wr_cnt_q] = row_y;
            wr_cnt_d                   = wr_cnt_q + 2'd1;
            if (wr_cnt_q == 2'd3) begin
                bank_st_d[wr_sel_q] = BANK_FULL;
                wr_sel_d            = ~wr_sel_q;
            end else begin
                bank_st_d[wr_sel_q] = BANK_FILLING;
            end
        end

        if (rd_fire) begin
            out_col_d   = col_res;
            out_valid_d = 1'b1;
            out_last_d  = (rd_cnt_q == 2'd3);
            rd_cnt_d    = rd_cnt_q + 2'd1;
            if (rd_cnt_q == 2'd3) begin
                bank_st_d[rd_sel_q] = BANK_EMPTY;
                rd_sel_d            = ~rd_sel_q;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_st_q[0] <= BANK_EMPTY;
            bank_st_q[1] <= BANK_EMPTY;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            wr_sel_q     <= 1'b0;
            rd_sel_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_col_q    <= '0;
        end else begin
            bank_st_q    <= bank_st_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_sel_q     <= wr_sel_d;
            rd_sel_q     <= rd_sel_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_col_q    <= out_col_d;
        end
    end

    always_ff @(posedge clk) begin
        bank_q <= bank_d;
    end

endmodule

// File: tb/tb_idct4x4_2d.sv
// Self-checking bench for idct4x4_2d against a plain-integer 2D transform model.
module tb_idct4x4_2d;

    localparam int IN_W    = 13;
    localparam int OUT_W   = 9;
    localparam int SHIFT   = 6;
    localparam int S_OUT_W = 8;
    localparam int S_SHIFT = 0;

    typedef logic [4*IN_W-1:0]    row_t;
    typedef logic [4*OUT_W-1:0]   col_t;
    typedef logic [4*S_OUT_W-1:0] scol_t;
    typedef row_t blk_t [4];
    typedef int   mat_t [4][4];

    logic  clk, rst_n;
    logic  in_valid, in_ready, out_valid, out_ready, out_last;
    row_t  in_row;
    col_t  out_col;
    logic  s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last;
    row_t  s_in_row;
    scol_t s_out_col;

    int    checks = 0;
    int    errors = 0;
    col_t  exp_col_q[$];
    logic  exp_last_q[$];
    mat_t  rowbuf;
    int    nrows = 0;

    idct4x4_2d #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
        .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col), .out_last(out_last)
    );

    idct4x4_2d #(.IN_W(IN_W), .OUT_W(S_OUT_W), .SHIFT(S_SHIFT)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_row(s_in_row),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_col(s_out_col),
        .out_last(s_out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic void bfly(input int x0, input int x1, input int x2, input int x3,
                                 output int y0, output int y1, output int y2, output int y3);
        int e0, e1, e2, e3;
        e0 = x0 + x2;
        e1 = x0 - x2;
        e2 = (x1 >>> 1) - x3;
        e3 = (x3 >>> 1) + x1;
        y0 = e0 + e3; y1 = e1 + e2; y2 = e1 - e2; y3 = e0 - e3;
    endfunction

    function automatic int rnd_sat(input int y, input int shift, input int out_w);
        int r, hi, lo;
        r  = (shift > 0) ? ((y + (1 <<< (shift - 1))) >>> shift) : y;
        hi = (1 <<< (out_w - 1)) - 1;
        lo = -(1 <<< (out_w - 1));
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r;
    endfunction

    // res[i][c] = output row i of column c
    task automatic model_block(input mat_t x, input int shift, input int out_w, output mat_t res);
        mat_t t;
        int y0, y1, y2, y3;
        for (int r = 0; r < 4; r++) begin
            bfly(x[r][0], x[r][1], x[r][2], x[r][3], t[r][0], t[r][1], t[r][2], t[r][3]);
        end
        for (int c = 0; c < 4; c++) begin
            bfly(t[0][c], t[1][c], t[2][c], t[3][c], y0, y1, y2, y3);
            res[0][c] = rnd_sat(y0, shift, out_w);
            res[1][c] = rnd_sat(y1, shift, out_w);
            res[2][c] = rnd_sat(y2, shift, out_w);
            res[3][c] = rnd_sat(y3, shift, out_w);
        end
    endtask

    function automatic row_t mk_row(input int a, input int b, input int c, input int d);
        return {IN_W'(d), IN_W'(c), IN_W'(b), IN_W'(a)};
    endfunction

    function automatic col_t const_col(input int v);
        col_t r;
        for (int i = 0; i < 4; i++) r[i*OUT_W +: OUT_W] = OUT_W'(v);
        return r;
    endfunction

    function automatic row_t rnd_row();
        return row_t'({$urandom(), $urandom()});
    endfunction

    task automatic push_row(input row_t row);
        mat_t res;
        col_t c;
        for (int k = 0; k < 4; k++) rowbuf[nrows][k] = int'($signed(row[k*IN_W +: IN_W]));
        nrows++;
        if (nrows == 4) begin
            model_block(rowbuf, SHIFT, OUT_W, res);
            for (int cc = 0; cc < 4; cc++) begin
                for (int i = 0; i < 4; i++) c[i*OUT_W +: OUT_W] = OUT_W'(res[i][cc]);
                exp_col_q.push_back(c);
                exp_last_q.push_back(cc == 3);
            end
            nrows = 0;
        end
    endtask

    task automatic reset_model();
        nrows = 0;
        exp_col_q.delete();
        exp_last_q.delete();
    endtask

    // One cycle on the main DUT: sample outputs at the falling edge, then drive inputs.
    task automatic cyc(input logic iv, input row_t row, input logic ordy,
                       output logic acc, output logic cons, output col_t col, output logic last);
        @(negedge clk);
        col       = out_col;
        last      = out_last;
        cons      = out_valid && ordy;
        acc       = iv && in_ready;
        in_valid  = iv;
        in_row    = row;
        out_ready = ordy;
        if (acc) push_row(row);
    endtask

    task automatic run_block(input blk_t b, output col_t got[4], output logic gl[4],
                             output int n, output int lat);
        int   sent, acc_at;
        logic acc, cons, l;
        col_t c;
        row_t nr;
        sent = 0; acc_at = 0; n = 0; lat = -1;
        for (int i = 0; i < 4; i++) begin got[i] = '0; gl[i] = 1'b0; end
        for (int t = 0; t < 40 && n < 4; t++) begin
            nr = '0;
            if (sent < 4) nr = b[sent];
            cyc(sent < 4, nr, 1'b1, acc, cons, c, l);
            if (cons) begin
                if (n == 0) lat = t - acc_at;
                got[n] = c; gl[n] = l; n++;
            end
            if (acc) begin
                sent++;
                if (sent == 4) acc_at = t;
            end
        end
        in_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_row = '0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_row = '0; s_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
        checks++; if (out_col !== '0) begin errors++; $display("FAIL reset_out_col: got %h expected 0", out_col); end
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL reset_sat_out_valid: got %b expected 0", s_out_valid); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_known_blocks();
        blk_t b[3];
        col_t want[3][4];
        col_t got[4];
        logic gl[4];
        int   n, lat;
        col_t e;
        logic el;
        b[0] = '{mk_row(64, 0, 0, 0), '0, '0, '0};
        b[1] = '{mk_row(0, 64, 0, 0), '0, '0, '0};
        b[2] = '{mk_row(-33, 0, 0, 0), '0, '0, '0};
        want[0] = '{const_col(1), const_col(1), const_col(1), const_col(1)};
        want[1] = '{const_col(1), const_col(1), const_col(0), const_col(-1)};
        want[2] = '{const_col(-1), const_col(-1), const_col(-1), const_col(-1)};
        for (int p = 0; p < 3; p++) begin
            run_block(b[p], got, gl, n, lat);
            checks++; if (n !== 4) begin errors++; $display("FAIL known%0d_count: got %0d columns expected 4", p, n); end
            checks++; if (lat !== 2) begin errors++; $display("FAIL known%0d_latency: got %0d expected 2", p, lat); end
            for (int c = 0; c < n; c++) begin
                e  = exp_col_q.pop_front();
                el = exp_last_q.pop_front();
                checks++; if (got[c] !== e) begin errors++; $display("FAIL known%0d_model_col%0d: got %h expected %h", p, c, got[c], e); end
                checks++; if (got[c] !== want[p][c]) begin errors++; $display("FAIL known%0d_const_col%0d: got %h expected %h", p, c, got[c], want[p][c]); end
                checks++; if (gl[c] !== el) begin errors++; $display("FAIL known%0d_last%0d: got %b expected %b", p, c, gl[c], el); end
            end
            reset_model();
        end
    endtask

    task automatic test_saturation();
        int    vals[2];
        int    lim[2];
        mat_t  x, res;
        scol_t e, k;
        int    sent, n;
        vals = '{200, -200};
        lim  = '{127, -128};
        for (int p = 0; p < 2; p++) begin
            x = '{default: 0};
            x[0][0] = vals[p];
            model_block(x, S_SHIFT, S_OUT_W, res);
            sent = 0; n = 0;
            for (int t = 0; t < 30 && n < 4; t++) begin
                @(negedge clk);
                if (s_out_valid) begin
                    for (int i = 0; i < 4; i++) begin
                        e[i*S_OUT_W +: S_OUT_W] = S_OUT_W'(res[i][n]);
                        k[i*S_OUT_W +: S_OUT_W] = S_OUT_W'(lim[p]);
                    end
                    checks++; if (s_out_col !== e) begin errors++; $display("FAIL sat%0d_model_col%0d: got %h expected %h", p, n, s_out_col, e); end
                    checks++; if (s_out_col !== k) begin errors++; $display("FAIL sat%0d_clamp_col%0d: got %h expected %h", p, n, s_out_col, k); end
                    checks++; if (s_out_last !== (n == 3)) begin errors++; $display("FAIL sat%0d_last%0d: got %b expected %b", p, n, s_out_last, (n == 3)); end
                    n++;
                end
                s_in_valid = (sent < 4);
                s_in_row   = (sent == 0) ? mk_row(vals[p], 0, 0, 0) : '0;
                if (s_in_valid && s_in_ready) sent++;
            end
            s_in_valid = 1'b0;
            checks++; if (n !== 4) begin errors++; $display("FAIL sat%0d_count: got %0d expected 4", p, n); end
        end
    endtask

    task automatic test_back_to_back();
        row_t rows[12];
        int   idx, ncol, acc_stall;
        logic acc, cons, l, ordy;
        col_t c, hold, e;
        logic el;
        idx = 0; ncol = 0; acc_stall = 0; hold = '0;
        for (int i = 0; i < 12; i++) rows[i] = rnd_row();
        for (int t = 0; t < 200 && ncol < 12; t++) begin
            ordy = (t >= 12);
            cyc(idx < 12, (idx < 12) ? rows[idx] : '0, ordy, acc, cons, c, l);
            if (t == 5) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_stalled_valid: got %b expected 1", out_valid); end
                hold = c;
            end
            if (t > 5 && t < 12) begin
                checks++; if (c !== hold) begin errors++; $display("FAIL b2b_stable_t%0d: got %h expected %h", t, c, hold); end
            end
            if (t == 11) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_full: got %b expected 0", in_ready); end
            end
            if (t < 12 && acc) acc_stall++;
            if (acc) idx++;
            if (cons) begin
                e  = exp_col_q.pop_front();
                el = exp_last_q.pop_front();
                checks++; if (c !== e) begin errors++; $display("FAIL b2b_col%0d: got %h expected %h", ncol, c, e); end
                checks++; if (l !== el) begin errors++; $display("FAIL b2b_last%0d: got %b expected %b", ncol, l, el); end
                ncol++;
            end
        end
        in_valid = 1'b0;
        checks++; if (acc_stall !== 8) begin errors++; $display("FAIL b2b_rows_accepted_in_stall: got %0d expected 8", acc_stall); end
        checks++; if (ncol !== 12) begin errors++; $display("FAIL b2b_column_count: got %0d expected 12", ncol); end
        reset_model();
    endtask

    task automatic test_random();
        int   sent, ncol;
        logic acc, cons, l, iv, ordy, prev_hold;
        col_t c, prev_col, e;
        logic el;
        row_t r;
        sent = 0; ncol = 0; prev_hold = 1'b0; prev_col = '0;
        r = rnd_row();
        for (int t = 0; t < 3000 && ncol < 24; t++) begin
            iv   = (sent < 24) && ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 7);
            cyc(iv, r, ordy, acc, cons, c, l);
            if (prev_hold) begin
                checks++; if (c !== prev_col || out_valid !== 1'b1) begin errors++; $display("FAIL rand_hold_t%0d: got %h/%b expected %h/1", t, c, out_valid, prev_col); end
            end
            prev_hold = out_valid && !ordy;
            prev_col  = c;
            if (acc) begin sent++; r = rnd_row(); end
            if (cons) begin
                e  = exp_col_q.pop_front();
                el = exp_last_q.pop_front();
                checks++; if (c !== e) begin errors++; $display("FAIL rand_col%0d: got %h expected %h", ncol, c, e); end
                checks++; if (l !== el) begin errors++; $display("FAIL rand_last%0d: got %b expected %b", ncol, l, el); end
                ncol++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (ncol !== 24) begin errors++; $display("FAIL rand_column_count: got %0d expected 24", ncol); end
        reset_model();
    endtask

    task automatic test_reset_mid();
        int   sent;
        logic acc, cons, l;
        col_t c, e;
        logic el;
        blk_t b;
        col_t got[4];
        logic gl[4];
        int   n, lat;
        sent = 0;
        for (int t = 0; t < 30 && sent < 6; t++) begin
            cyc(1'b1, rnd_row(), 1'b0, acc, cons, c, l);
            if (acc) sent++;
        end
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_col !== '0 || out_last !== 1'b0) begin errors++; $display("FAIL mid_reset_out_col: got %h/%b expected 0/0", out_col, out_last); end
        rst_n = 1'b1; out_ready = 1'b1;
        reset_model();
        for (int i = 0; i < 4; i++) b[i] = rnd_row();
        run_block(b, got, gl, n, lat);
        checks++; if (n !== 4) begin errors++; $display("FAIL mid_reset_count: got %0d expected 4", n); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL mid_reset_latency: got %0d expected 2", lat); end
        for (int k = 0; k < n; k++) begin
            e  = exp_col_q.pop_front();
            el = exp_last_q.pop_front();
            checks++; if (got[k] !== e) begin errors++; $display("FAIL mid_reset_col%0d: got %h expected %h", k, got[k], e); end
            checks++; if (gl[k] !== el) begin errors++; $display("FAIL mid_reset_last%0d: got %b expected %b", k, gl[k], el); end
        end
        reset_model();
    endtask

    initial begin
        test_reset();
        test_known_blocks();
        test_saturation();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
